seq_sort: RTL and testbench



---
 rtl/sort_pkg.sv | 19 +
 rtl/cmp_swap.sv | 22 ++
 rtl/seq_sort.sv | 179 +++++++++++++++++
 tb/tb_seq_sort.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and helpers for the sequential odd-even transposition sorter.
package sort_pkg;

  // Controller states: idle/accepting, sorting one phase per cycle, result held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit offset of element k inside a packed vector of n elements of w bits.
  // Element 0 sits in the most significant slice.
  function automatic int unsigned elem_idx(input int unsigned k,
                                           input int unsigned n,
                                           input int unsigned w);
    return (n - 1 - k) * w;
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// Single compare-exchange cell. lo_out lands at the lower element index of the
// pair; the pair is swapped only when strictly out of order, so ties keep
// their original order.
module cmp_swap #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             descend,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             swapped
);

  // Unsigned compare; direction picks which strict inequality forces a swap.
  always_comb begin
    swapped = descend ? (x < y) : (x > y);
    lo_out  = swapped ? y : x;
    hi_out  = swapped ? x : y;
  end

endmodule

// File: rtl/seq_sort.sv
// Sequential sorter: one odd-even transposition phase per clock, with early
// exit after two consecutive phases that made no swaps.
module seq_sort
  import sort_pkg::*;
#(
  parameter  int NUM_VALS = 8,
  parameter  int WIDTH    = 4,
  localparam int PW       = $clog2(NUM_VALS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_VALS*WIDTH-1:0] A,
  input  logic                      descend,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_VALS*WIDTH-1:0] B,
  output logic [PW-1:0]             phases,
  output logic                      busy
);

  localparam int VW  = NUM_VALS * WIDTH;
  localparam int NE  = NUM_VALS / 2;
  localparam int NO  = (NUM_VALS - 1) / 2;
  localparam int NOA = (NO > 0) ? NO : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_VALS);

  state_e          state_q, state_d;
  logic [VW-1:0]   work_q, work_d;
  logic [VW-1:0]   b_q, b_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   phases_q, phases_d;
  logic            desc_q, desc_d;
  logic            noswap_q, noswap_d;

  logic [WIDTH-1:0] cur [NUM_VALS];
  logic [WIDTH-1:0] ev_lo [NE];
  logic [WIDTH-1:0] ev_hi [NE];
  logic [NE-1:0]    ev_sw;
  logic [WIDTH-1:0] od_lo [NOA];
  logic [WIDTH-1:0] od_hi [NOA];
  logic [NOA-1:0]   od_sw;
  logic [VW-1:0]    ev_vec, od_vec, phase_vec;
  logic             phase_swapped;
  logic [PW-1:0]    cnt_inc;

  // Even bank compares (0,1),(2,3),...
  for (genvar i = 0; i < NE; i++) begin : g_even
    cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .x      (cur[2*i]),
      .y      (cur[2*i+1]),
      .descend(desc_q),
      .lo_out (ev_lo[i]),
      .hi_out (ev_hi[i]),
      .swapped(ev_sw[i])
    );
  end

  // Odd bank compares (1,2),(3,4),...; empty when there are only two elements.
  if (NO > 0) begin : g_odd
    for (genvar i = 0; i < NO; i++) begin : g_cell
      cmp_swap #(.WIDTH(WIDTH)) u_cs (
        .x      (cur[2*i+1]),
        .y      (cur[2*i+2]),
        .descend(desc_q),
        .lo_out (od_lo[i]),
        .hi_out (od_hi[i]),
        .swapped(od_sw[i])
      );
    end
  end else begin : g_no_odd
    assign od_lo[0] = '0;
    assign od_hi[0] = '0;
    assign od_sw    = '0;
  end

  // Unpack the working register and repack each bank's result; elements not
  // covered by a bank pass straight through.
  for (genvar k = 0; k < NUM_VALS; k++) begin : g_el
    localparam int unsigned BASE = elem_idx(k, NUM_VALS, WIDTH);
    assign cur[k] = work_q[BASE +: WIDTH];

    if (k / 2 < NE) begin : g_ev_pair
      if (k % 2 == 0) begin : g_lo
        assign ev_vec[BASE +: WIDTH] = ev_lo[k/2];
      end else begin : g_hi
        assign ev_vec[BASE +: WIDTH] = ev_hi[k/2];
      end
    end else begin : g_ev_pass
      assign ev_vec[BASE +: WIDTH] = cur[k];
    end

    if (k >= 1 && (k - 1) / 2 < NO) begin : g_od_pair
      if (k % 2 == 1) begin : g_lo
        assign od_vec[BASE +: WIDTH] = od_lo[(k-1)/2];
      end else begin : g_hi
        assign od_vec[BASE +: WIDTH] = od_hi[(k-1)/2];
      end
    end else begin : g_od_pass
      assign od_vec[BASE +: WIDTH] = cur[k];
    end
  end

  // Phase parity selects which bank is applied this cycle.
  always_comb begin
    phase_vec     = cnt_q[0] ? od_vec : ev_vec;
    phase_swapped = cnt_q[0] ? (|od_sw) : (|ev_sw);
    cnt_inc       = cnt_q + PW'(1);
  end

  // State and datapath registers; reset drops any vector in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      phases_q <= '0;
      desc_q   <= 1'b0;
      noswap_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      phases_q <= phases_d;
      desc_q   <= desc_d;
      noswap_q <= noswap_d;
    end
  end

  // Next-state logic: accept, step one phase, or wait for the consumer.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    phases_d = phases_q;
    desc_d   = desc_q;
    noswap_d = noswap_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d   = A;
          desc_d   = descend;
          cnt_d    = '0;
          noswap_d = 1'b0;
          state_d  = SORT;
        end
      end
      SORT: begin
        work_d   = phase_vec;
        cnt_d    = cnt_inc;
        noswap_d = !phase_swapped;
        // noswap_q is cleared on accept, so the early exit needs two phases.
        if (cnt_inc == LAST_PHASE || (!phase_swapped && noswap_q)) begin
          b_d      = phase_vec;
          phases_d = cnt_inc;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decode directly from the state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == SORT);
    out_valid = (state_q == DONE);
    B         = b_q;
    phases    = phases_q;
  end

endmodule

// File: tb/tb_seq_sort.sv
// Scoreboard bench for seq_sort: stimulus pushes expected results, a monitor
// pops and compares whenever a result is handed over.
module tb_seq_sort;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int PW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*W-1:0]  A = '0;
  logic            descend = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N*W-1:0]  B;
  logic [PW-1:0]   phases;
  logic            busy;

  seq_sort #(.NUM_VALS(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .descend  (descend),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .B        (B),
    .phases   (phases),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] b;
    int          p;
    int          acc;
  } exp_t;
  exp_t sb[$];

  bit rand_rdy  = 1'b0;
  bit force_rdy = 1'b1;
  int consume_cyc = -1;
  int last_acc = -1;

  // out_ready changes just after each rising edge so nothing races the DUT.
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out (t=%0t)", nm, $time);
  endtask

  // Reference: plain sort for the values, array-level transposition for the
  // phase count with the two-clean-phases early exit.
  function automatic void ref_sort(input logic [31:0] a, input bit d,
                                   output logic [31:0] b, output int p);
    int v[N];
    int s[N];
    int t;
    int sw;
    bit clean_prev;
    for (int k = 0; k < N; k++) v[k] = int'(a[(N-1-k)*W +: W]);
    s = v;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (d ? (s[j] > s[i]) : (s[j] < s[i])) begin
          t = s[i]; s[i] = s[j]; s[j] = t;
        end
    b = '0;
    for (int k = 0; k < N; k++) b[(N-1-k)*W +: W] = 4'(s[k]);
    p = 0;
    clean_prev = 1'b0;
    for (int ph = 0; ph < N; ph++) begin
      sw = 0;
      for (int i = ph % 2; i + 1 < N; i += 2)
        if (d ? (v[i] < v[i+1]) : (v[i] > v[i+1])) begin
          t = v[i]; v[i] = v[i+1]; v[i+1] = t;
          sw++;
        end
      p = ph + 1;
      if (sw == 0 && clean_prev) break;
      clean_prev = (sw == 0);
    end
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] a, input bit d, input bit push,
                      input logic [31:0] eb, input int ep);
    int n;
    in_valid = 1'b1;
    A        = a;
    descend  = d;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("accept");
      in_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    if (push) sb.push_back('{b: eb, p: ep, acc: cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
    A        = $urandom;
    descend  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) fail_now("drain");
  endtask

  // Monitor: handshake rules, backpressure stability, and scoreboard pops.
  initial begin
    bit             prev_ov = 1'b0;
    bit             prev_or = 1'b0;
    logic [31:0]    prev_b  = '0;
    logic [PW-1:0]  prev_p  = '0;
    int             rise_cyc = 0;
    exp_t           e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_ov = 1'b0;
        continue;
      end
      if (out_valid) begin
        chk("ov_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("ov_busy_low", {63'd0, busy}, 64'd0);
        chk("phases_range", {63'd0, (phases >= 2 && phases <= N)}, 64'd1);
        if (!prev_ov) rise_cyc = cyc;
        else if (!prev_or) begin
          chk("stall_B_stable", B, prev_b);
          chk("stall_phases_stable", phases, prev_p);
        end
        if (out_ready) begin
          consume_cyc = cyc + 1;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result B=%0h phases=%0d", B, phases);
          end else begin
            e = sb.pop_front();
            chk("result_B", B, e.b);
            chk("result_phases", phases, e.p);
            chk("result_latency", rise_cyc - e.acc, e.p);
          end
        end
      end else if (in_ready && busy) begin
        chk("ready_busy_exclusive", 64'd1, 64'd0);
      end
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_b  = B;
      prev_p  = phases;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mb;
    int          mp;
    int          n;

    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_B", B, 64'd0);
    chk("reset_phases", phases, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed vectors from the test plan.
    send(32'h8765_4321, 1'b0, 1'b1, 32'h1234_5678, 8);
    drain();
    send(32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 2);
    drain();
    send(32'h1234_5678, 1'b1, 1'b1, 32'h8765_4321, 8);
    drain();
    ref_sort(32'h3131_3131, 1'b0, mb, mp);
    send(32'h3131_3131, 1'b0, 1'b1, 32'h1111_3333, mp);
    drain();
    ref_sort(32'h7707_0770, 1'b1, mb, mp);
    send(32'h7707_0770, 1'b1, 1'b1, 32'h7777_7000, mp);
    drain();

    // Backpressure: hold the result, keep a new vector pending meanwhile.
    force_rdy = 1'b0;
    @(negedge clk);
    ref_sort(32'h5A3C_9E17, 1'b0, mb, mp);
    send(32'h5A3C_9E17, 1'b0, 1'b1, 32'h1357_9ACE, mp);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("bp_wait_out_valid");
    in_valid = 1'b1;
    A        = 32'h8765_4321;
    descend  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid_high", {63'd0, out_valid}, 64'd1);
    end
    force_rdy = 1'b1;
    send(32'h8765_4321, 1'b0, 1'b1, 32'h1234_5678, 8);
    chk("bp_accept_after_consume", last_acc, consume_cyc + 1);
    drain();

    // Asynchronous reset in the middle of a sort.
    send(32'h8765_4321, 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midsort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midsort_B", B, 64'd0);
    chk("midsort_phases", phases, 64'd0);
    chk("midsort_busy", {63'd0, busy}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    ref_sort(32'hF0E1_D2C3, 1'b0, mb, mp);
    send(32'hF0E1_D2C3, 1'b0, 1'b1, 32'h0123_CDEF, mp);
    drain();

    // Random vectors against the reference, with random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      bit          d;
      a = $urandom;
      d = 1'($urandom_range(0, 1));
      ref_sort(a, d, mb, mp);
      send(a, d, 1'b1, mb, mp);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_rdy  = 1'b0;
    force_rdy = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
